// File: rtl/fft_twiddle_gen.sv
// Radix-2 FFT twiddle generator: quarter-wave cosine table, 3-stage valid/ready
// pipeline, optional conjugate output and a per-stage burst sequencer.
module fft_twiddle_gen #(
  parameter  int N           = 256,
  parameter  int COEFF_WIDTH = 16,
  parameter  int COEFF_FRAC  = 14,
  localparam int LOG2N       = $clog2(N),
  localparam int SW          = $clog2(LOG2N),
  localparam int KW          = LOG2N - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SW-1:0]                 req_stage,
  input  logic [KW-1:0]                 req_idx,
  input  logic                          inv,
  input  logic                          seq_start,
  input  logic [SW-1:0]                 seq_stage,
  output logic                          seq_busy,
  output logic                          tw_valid,
  input  logic                          tw_ready,
  output logic signed [COEFF_WIDTH-1:0] tw_re,
  output logic signed [COEFF_WIDTH-1:0] tw_im,
  output logic                          tw_last
);

  localparam int QTR = N / 4;

  if (COEFF_FRAC > COEFF_WIDTH - 2) begin : g_bad_frac
    $error("fft_twiddle_gen: COEFF_FRAC must be <= COEFF_WIDTH-2");
  end

  // Elaboration-time cosine via Taylor series, rounded half away from zero
  // (argument never exceeds pi/2, so the result is non-negative).
  function automatic int cos_q(int i);
    real x, term, sum, scale;
    x    = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 24; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int b = 0; b < COEFF_FRAC; b++) scale = scale * 2.0;
    return $rtoi(sum * scale + 0.5);
  endfunction

  function automatic logic [SW-1:0] clamp_stage(logic [SW-1:0] s);
    return (int'(s) >= LOG2N) ? SW'(LOG2N - 1) : s;
  endfunction

  function automatic logic [KW-1:0] stage_mask(logic [SW-1:0] s);
    return KW'((32'd1 << s) - 32'd1);
  endfunction

  // NOTE: the table is pure constants feeding combinational reads, so it needs no reset.
  logic [COEFF_WIDTH-1:0] cos_tab [QTR+1];
  for (genvar g = 0; g <= QTR; g++) begin : g_tab
    assign cos_tab[g] = COEFF_WIDTH'(cos_q(g));
  end

  typedef enum logic {IDLE, RUN} seq_state_t;

  typedef struct packed {
    logic          valid;
    logic [KW-1:0] re_addr;
    logic [KW-1:0] im_addr;
    logic          re_neg;
    logic          im_neg;
    logic          last;
  } p1_t;

  typedef struct packed {
    logic                   valid;
    logic [COEFF_WIDTH-1:0] re_mag;
    logic [COEFF_WIDTH-1:0] im_mag;
    logic                   re_neg;
    logic                   im_neg;
    logic                   last;
  } p2_t;

  seq_state_t    state, state_d;
  logic [SW-1:0] run_stage, run_stage_d;
  logic [KW-1:0] run_j, run_j_d;
  logic          run_inv, run_inv_d;
  logic          en;
  logic          src_valid, src_inv, src_last;
  logic [SW-1:0] src_stage;
  logic [KW-1:0] src_idx, k;
  p1_t           p1, p1_d;
  p2_t           p2;

  assign en        = !tw_valid || tw_ready;
  assign seq_busy  = (state == RUN);
  assign req_ready = en && !seq_busy && !seq_start;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state;
    run_stage_d = run_stage;
    run_j_d     = run_j;
    run_inv_d   = run_inv;
    case (state)
      IDLE: if (seq_start) begin
        state_d     = RUN;
        run_stage_d = clamp_stage(seq_stage);
        run_inv_d   = inv;
        run_j_d     = '0;
      end
      RUN: if (en) begin
        run_j_d = run_j + KW'(1);
        if (run_j == stage_mask(run_stage)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_stage <= '0;
      run_j     <= '0;
      run_inv   <= 1'b0;
    end else begin
      state     <= state_d;
      run_stage <= run_stage_d;
      run_j     <= run_j_d;
      run_inv   <= run_inv_d;
    end
  end

  // The sequencer owns P1 while running; otherwise an accepted request does.
  always_comb begin
    src_valid = req_valid && req_ready;
    src_stage = clamp_stage(req_stage);
    src_idx   = req_idx;
    src_inv   = inv;
    src_last  = 1'b0;
    if (state == RUN) begin
      src_valid = 1'b1;
      src_stage = run_stage;
      src_idx   = run_j;
      src_inv   = run_inv;
      src_last  = (run_j == stage_mask(run_stage));
    end
  end

  always_comb begin
    k           = (src_idx & stage_mask(src_stage)) << (SW'(LOG2N - 1) - src_stage);
    p1_d        = '0;
    p1_d.valid  = src_valid;
    p1_d.im_neg = !src_inv;
    p1_d.last   = src_last;
    if (k <= KW'(QTR)) begin
      p1_d.re_addr = k;
      p1_d.im_addr = KW'(QTR) - k;
    end else begin
      p1_d.re_addr = KW'(N / 2 - int'(k));
      p1_d.im_addr = k - KW'(QTR);
      p1_d.re_neg  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1       <= '0;
      p2       <= '0;
      tw_valid <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
      tw_last  <= 1'b0;
    end else if (en) begin
      p1        <= p1_d;
      p2.valid  <= p1.valid;
      p2.re_mag <= cos_tab[p1.re_addr];
      p2.im_mag <= cos_tab[p1.im_addr];
      p2.re_neg <= p1.re_neg;
      p2.im_neg <= p1.im_neg;
      p2.last   <= p1.last;
      tw_valid  <= p2.valid;
      tw_re     <= p2.re_neg ? -$signed(p2.re_mag) : $signed(p2.re_mag);
      tw_im     <= p2.im_neg ? -$signed(p2.im_mag) : $signed(p2.im_mag);
      tw_last   <= p2.last;
    end
  end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Self-checking bench for fft_twiddle_gen: directed plan scenarios plus randomized
// requests/bursts scored against a floating-point twiddle model.
module tb_fft_twiddle_gen;

  localparam int N     = 256;
  localparam int CW    = 16;
  localparam int CF    = 14;
  localparam int LOG2N = 8;
  localparam int SW    = 3;
  localparam int KW    = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid, req_ready, inv, seq_start, seq_busy;
  logic [SW-1:0]        req_stage, seq_stage;
  logic [KW-1:0]        req_idx;
  logic                 tw_valid, tw_ready, tw_last;
  logic signed [CW-1:0] tw_re, tw_im;

  fft_twiddle_gen #(.N(N), .COEFF_WIDTH(CW), .COEFF_FRAC(CF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_stage(req_stage), .req_idx(req_idx),
    .inv(inv), .seq_start(seq_start), .seq_stage(seq_stage), .seq_busy(seq_busy),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im), .tw_last(tw_last)
  );

  always #5 clk = ~clk;

  typedef struct { int re; int im; bit last; } exp_t;
  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0, out_count = 0;
  bit   rand_bp = 1'b0;

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int clamp_s(int s);
    return (s >= LOG2N) ? LOG2N - 1 : s;
  endfunction

  // W_N^k = cos(2pi k/N) - j sin(2pi k/N), conjugated when inverse
  function automatic exp_t model(int s, int j, bit iv, bit last);
    exp_t e;
    int   sc, k, m;
    real  a, scale;
    sc     = clamp_s(s);
    k      = (j % (1 << sc)) * N / (1 << (sc + 1));
    a      = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    scale  = real'(1 << CF);
    e.re   = rnd($cos(a) * scale);
    m      = rnd($sin(a) * scale);
    e.im   = iv ? m : -m;
    e.last = last;
    return e;
  endfunction

  // Scoreboard and hold-under-backpressure monitor
  initial begin : monitor
    logic [2*CW+1:0] held;
    bit              stalled;
    exp_t            e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          vectors++;
          if ({tw_valid, tw_re, tw_im, tw_last} !== held) begin
            miscompares++;
            $display("FAIL stall_hold: got %h required %h", {tw_valid, tw_re, tw_im, tw_last}, held);
          end
        end
        if (tw_valid && tw_ready) begin
          vectors++;
          out_count++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got re=%0d im=%0d with nothing expected", tw_re, tw_im);
          end else begin
            e = exp_q.pop_front();
            if (int'(tw_re) !== e.re || int'(tw_im) !== e.im || tw_last !== e.last) begin
              miscompares++;
              $display("FAIL twiddle: got (%0d,%0d,last=%0b) required (%0d,%0d,last=%0b)",
                       tw_re, tw_im, tw_last, e.re, e.im, e.last);
            end
          end
        end
        stalled = tw_valid && !tw_ready;
        held    = {tw_valid, tw_re, tw_im, tw_last};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) tw_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue_req(int s, int j, bit iv);
    bit accepted = 1'b0;
    req_valid = 1'b1;
    req_stage = SW'(s);
    req_idx   = KW'(j);
    inv       = iv;
    for (int c = 0; c < 400 && !accepted; c++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(model(s, j, iv, 1'b0));
        accepted = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!accepted) begin
      miscompares++;
      $display("FAIL req_accept: got no acceptance required acceptance within 400 cycles");
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 2000 && seq_busy; c++) tick();
  endtask

  task automatic start_burst(int s, bit iv);
    int sc = clamp_s(s);
    wait_idle();
    seq_start = 1'b1;
    seq_stage = SW'(s);
    inv       = iv;
    for (int j = 0; j < (1 << sc); j++) exp_q.push_back(model(sc, j, iv, j == (1 << sc) - 1));
    tick();
    seq_start = 1'b0;
    vectors++;
    if (seq_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_start: got seq_busy=%0b required 1", seq_busy);
    end
  endtask

  task automatic drain();
    int c;
    for (c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0 && !tw_valid && !seq_busy) break;
      tick();
    end
    vectors++;
    if (c == 3000) begin
      miscompares++;
      $display("FAIL drain: got %0d outputs pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; seq_start = 1'b0; tw_ready = 1'b1; inv = 1'b0;
    req_stage = '0; req_idx = '0; seq_stage = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 6;
    if (tw_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tw_valid: got %0b required 0", tw_valid); end
    if (tw_re !== '0) begin miscompares++; $display("FAIL rst_tw_re: got %0d required 0", tw_re); end
    if (tw_im !== '0) begin miscompares++; $display("FAIL rst_tw_im: got %0d required 0", tw_im); end
    if (tw_last !== 1'b0) begin miscompares++; $display("FAIL rst_tw_last: got %0b required 0", tw_last); end
    if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL rst_seq_busy: got %0b required 0", seq_busy); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %0b required 1", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // One isolated request: checks the 3-cycle latency and the exact values.
  task automatic directed_one(int s, int j, bit iv, int exp_re, int exp_im);
    issue_req(s, j, iv);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      vectors++;
      if (n < 3) begin
        if (tw_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL latency_early: got tw_valid=1 after %0d cycles required 0", n);
        end
      end else if (tw_valid !== 1'b1 || int'(tw_re) !== exp_re || int'(tw_im) !== exp_im || tw_last !== 1'b0) begin
        miscompares++;
        $display("FAIL directed s=%0d j=%0d inv=%0b: got v=%0b (%0d,%0d,last=%0b) required v=1 (%0d,%0d,last=0)",
                 s, j, iv, tw_valid, tw_re, tw_im, tw_last, exp_re, exp_im);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_directed();
    directed_one(7, 0, 1'b0, 16384, 0);
    directed_one(7, 32, 1'b0, 11585, -11585);
    directed_one(7, 32, 1'b1, 11585, 11585);
    directed_one(1, 1, 1'b0, 0, -16384);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 16; j++) issue_req($urandom_range(0, 7), $urandom_range(0, 127), 1'(j));
    drain();
  endtask

  task automatic test_burst_s2();
    int busy = 0;
    tw_ready = 1'b1;
    start_burst(2, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!seq_busy) break;
      busy++;
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL burst_req_ready: got 1 required 0"); end
      tick();
    end
    vectors++;
    if (busy !== 4) begin miscompares++; $display("FAIL burst_busy_len: got %0d cycles required 4", busy); end
    drain();
  endtask

  task automatic test_backpressure();
    int base = out_count;
    tw_ready = 1'b1;
    start_burst(7, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 200 && out_count - base < 20; c++) begin
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready: got 1 required 0"); end
      tick();
    end
    tw_ready = 1'b0;
    repeat (5) begin
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready_stall: got 1 required 0"); end
      tick();
    end
    tw_ready = 1'b1;
    for (int c = 0; c < 400 && seq_busy; c++) begin
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready_resume: got 1 required 0"); end
      tick();
    end
    drain();
    vectors++;
    if (out_count - base !== 128) begin
      miscompares++;
      $display("FAIL bp_count: got %0d outputs required 128", out_count - base);
    end
  endtask

  task automatic test_collision();
    int busy = 0;
    tw_ready  = 1'b1;
    wait_idle();
    seq_start = 1'b1; seq_stage = 3'd3; inv = 1'b0;
    req_valid = 1'b1; req_stage = 3'd7; req_idx = 7'd5;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL collide_req_ready: got 1 required 0"); end
    for (int j = 0; j < 8; j++) exp_q.push_back(model(3, j, 1'b0, j == 7));
    tick();
    seq_start = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!seq_busy) break;
      busy++;
      tick();
      seq_start = (busy == 2);
      seq_stage = 3'd5;
      inv       = 1'b1;
    end
    seq_start = 1'b0;
    vectors++;
    if (busy !== 8) begin miscompares++; $display("FAIL collide_busy_len: got %0d cycles required 8", busy); end
    drain();
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    tw_ready = 1'b1;
    issue_req(7, 16, 1'b0);
    issue_req(7, 48, 1'b0);
    issue_req(7, 80, 1'b1);
    rst = 1'b1;
    #1;
    vectors += 2;
    if ({tw_valid, tw_re, tw_im, tw_last} !== '0) begin
      miscompares++;
      $display("FAIL rst_inflight_out: got v=%0b (%0d,%0d,%0b) required all 0", tw_valid, tw_re, tw_im, tw_last);
    end
    if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL rst_inflight_busy: got 1 required 0"); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tw_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL rst_ghost_output: got tw_valid=1 after reset required 0"); end
    tick();
  endtask

  task automatic test_sweep();
    rand_bp = 1'b1;
    for (int k = 0; k < 128; k++) issue_req(7, k, 1'($urandom_range(0, 1)));
    drain();
    rand_bp = 1'b0; tw_ready = 1'b1;
  endtask

  task automatic test_random_mix();
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) start_burst($urandom_range(0, 5), 1'($urandom_range(0, 1)));
      else issue_req($urandom_range(0, 7), $urandom_range(0, 127), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_bp = 1'b0; tw_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_burst_s2();
    test_backpressure();
    test_collision();
    test_reset_inflight();
    test_sweep();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
